// File: rtl/op_sched_pkg.sv
// op_sched_pkg: shared encodings for the op_scheduler block.
// Holds the FSM state encoding, command mode values, command field positions
// and a small sizing helper used for the shared sequencing counter.
package op_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam logic [3:0] MODE_CALC  = 4'd1;
    localparam logic [3:0] MODE_WRITE = 4'd2;

    // Command word layout: [3:0] mode, [7:4] a, [11:8] b, [15:12] c,
    // [16] relu, [17] store B.
    localparam int CMD_W           = 18;
    localparam int CMD_MODE_LSB    = 0;
    localparam int CMD_A_LSB       = 4;
    localparam int CMD_B_LSB       = 8;
    localparam int CMD_C_LSB       = 12;
    localparam int CMD_RELU_BIT    = 16;
    localparam int CMD_STORE_B_BIT = 17;

    // a[3] selects the W bank (short burst) instead of the X bank.
    localparam int W_SEL_BIT = CMD_A_LSB + 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/op_scheduler_sched_cnt.sv
// sched_cnt: loadable down-counter with a terminal-count flag.
// One instance is shared by the WRITE, COMPUTE and DRAIN phases; each phase
// loads (length - 1) on entry and tc_o marks the final cycle/beat.
module sched_cnt #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: load has priority; decrement holds at zero.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/op_scheduler.sv
// op_scheduler: accepts host commands and sequences the DNN controller.
// WRITE streams a W/X burst, COMPUTE holds the mode-1 word for the full
// iteration count, DRAIN drives mode 0 to flush the multiplier pipeline.
// Optional macro OP_SCHED_PERF_CNT_EN adds saturating busy/stall counters;
// without it perf_busy and perf_stall are tied to zero.
module op_scheduler
    import op_sched_pkg::*;
#(
    parameter int W_WORDS      = 32,
    parameter int X_WORDS      = 80,
    parameter int X_BLOCKS     = 2,
    parameter int DRAIN_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic [31:0] op_out,
    output logic [31:0] data_out,
    output logic        ctl_enable,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] perf_busy,
    output logic [31:0] perf_stall
);

    localparam int CALC_CYCLES = W_WORDS * X_BLOCKS;
    localparam int CNT_MAX     = max3(X_WORDS, CALC_CYCLES, DRAIN_CYCLES);
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] W_LAST     = CNT_W'(W_WORDS - 1);
    localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(X_WORDS - 1);
    localparam logic [CNT_W-1:0] CALC_LAST  = CNT_W'(CALC_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             idle_ready;
    logic             cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0] cnt_load_val;
    logic [3:0]       cmd_mode;

    assign cmd_mode = cmd_data[CMD_MODE_LSB +: 4];

    sched_cnt #(.WIDTH(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_ni     (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // State, latched command, sticky error and completion pulse registers.
    // NOTE: only control state is reset; no memories live here, so every flop gets a reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next-state decode and controller-facing outputs.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        err_d        = err_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        idle_ready   = 1'b0;
        wr_ready     = 1'b0;
        ctl_enable   = 1'b0;
        op_out       = '0;
        data_out     = '0;
        unique case (state_q)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_d = cmd_data;
                    if (cmd_mode == MODE_WRITE) begin
                        state_d      = ST_WRITE;
                        cnt_load     = 1'b1;
                        cnt_load_val = cmd_data[W_SEL_BIT] ? W_LAST : X_LAST;
                    end else if (cmd_mode == MODE_CALC) begin
                        state_d      = ST_COMPUTE;
                        cnt_load     = 1'b1;
                        cnt_load_val = CALC_LAST;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                op_out   = {{(32-CMD_W){1'b0}}, cmd_q};
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ctl_enable = 1'b1;
                    data_out   = wr_data;
                    cnt_dec    = 1'b1;
                    if (cnt_tc) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                op_out     = {{(32-CMD_W){1'b0}}, cmd_q};
                ctl_enable = 1'b1;
                cnt_dec    = 1'b1;
                if (cnt_tc) begin
                    state_d      = ST_DRAIN;
                    cnt_load     = 1'b1;
                    cnt_load_val = DRAIN_LAST;
                end
            end
            ST_DRAIN: begin
                ctl_enable = 1'b1;
                cnt_dec    = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Reset state is IDLE, so ready is masked by reset to stay low while held.
    assign cmd_ready = idle_ready & reset;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

`ifdef OP_SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    // Saturating busy-cycle and write-stall counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == ST_WRITE) && !wr_valid && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: directed table-driven bench for op_scheduler, plus
// hand-written sequences for back-to-back compute and reset mid-compute.
module tb_op_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [17:0] cmd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [31:0] op_out;
    logic [31:0] data_out;
    logic        ctl_enable;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;

    int tests  = 0;
    int failed = 0;
    int exp_busy_tot  = 0;
    int exp_stall_tot = 0;

    op_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .op_out     (op_out),
        .data_out   (data_out),
        .ctl_enable (ctl_enable),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] cmd;
        int          stall_n;    // 0: wr_valid always high, else low when cyc % stall_n == 0
        int          exp_done;   // cycle after accept at which done is high
        int          exp_en;     // ctl_enable cycles before done
        int          exp_hi;     // cycles 1..exp_hi carry the command word on op_out
        logic        exp_err;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to done. Entered and left at #1 after a posedge.
    task automatic run_vec(input vec_t v, input int idx);
        int          en_cnt, op_bad, data_bad, done_at, beat;
        logic [3:0]  m;
        logic        is_write, drive_v;
        logic [31:0] word, exp_op;
        en_cnt = 0; op_bad = 0; data_bad = 0; done_at = 0; beat = 0;
        m        = v.cmd[3:0];
        is_write = (m == 4'd2);
        word     = {14'b0, v.cmd};
        cmd_valid = 1'b1;
        cmd_data  = v.cmd;
        wr_valid  = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_cmd_ready", idx), {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            drive_v  = (v.stall_n == 0) ? 1'b1 : ((cyc % v.stall_n) != 0);
            wr_valid = drive_v;
            wr_data  = {8'(idx), 24'(beat)};
            @(negedge clk);
            if (done) begin
                done_at = cyc;
                break;
            end
            if (ctl_enable) en_cnt++;
            exp_op = (cyc <= v.exp_hi) ? word : 32'd0;
            if (op_out !== exp_op) op_bad++;
            if (is_write && cyc < v.exp_done) begin
                if (drive_v) begin
                    if (!ctl_enable || !wr_ready || data_out !== wr_data) data_bad++;
                    beat++;
                end else if (ctl_enable || !wr_ready) begin
                    data_bad++;
                end
            end
            @(posedge clk); #1;
        end
        exp_busy_tot  += v.exp_done - 1;
        exp_stall_tot += v.exp_stalls;
        check($sformatf("v%0d_done_cycle", idx), 32'(done_at), 32'(v.exp_done));
        check($sformatf("v%0d_enable_cycles", idx), 32'(en_cnt), 32'(v.exp_en));
        check($sformatf("v%0d_op_out_errors", idx), 32'(op_bad), 32'd0);
        check($sformatf("v%0d_data_errors", idx), 32'(data_bad), 32'd0);
        check($sformatf("v%0d_busy_at_done", idx), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, v.exp_err});
`ifdef OP_SCHED_PERF_CNT_EN
        check($sformatf("v%0d_perf_stall", idx), perf_stall, 32'(exp_stall_tot));
        check($sformatf("v%0d_perf_busy", idx), perf_busy, 32'(exp_busy_tot));
`else
        check($sformatf("v%0d_perf_stall", idx), perf_stall, 32'd0);
        check($sformatf("v%0d_perf_busy", idx), perf_busy, 32'd0);
`endif
        wr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int accepts, dones, first_end, second_start;
        logic prev_m1, now_m1, second_at_done;

        //          cmd         stall done  en  hi   err  stalls
        vecs[0] = '{18'h00082, 0,    33,  32, 32,  1'b0, 0};   // W burst, no stalls
        vecs[1] = '{18'h00002, 3,    120, 80, 119, 1'b0, 39};  // X burst, stall every 3rd cycle
        vecs[2] = '{18'h10001, 0,    80,  79, 64,  1'b0, 0};   // compute + drain
        vecs[3] = '{18'h00007, 0,    1,   0,  0,   1'b1, 0};   // illegal mode
        vecs[4] = '{18'h20082, 0,    33,  32, 32,  1'b1, 0};   // write after error, err sticks

        reset = 1'b0; cmd_valid = 1'b0; cmd_data = '0; wr_valid = 1'b0; wr_data = '0;
        #12;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        check("rst_ctl_enable", {31'b0, ctl_enable}, 32'd0);
        check("rst_op_out", op_out, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_flags", {28'b0, busy, done, err, 1'b0}, 32'd0);
        check("rst_perf", perf_busy | perf_stall, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Back-to-back compute commands with cmd_valid held high.
        accepts = 0; dones = 0; first_end = -1; second_start = -1;
        prev_m1 = 1'b0; second_at_done = 1'b0;
        cmd_data = 18'h00001;
        for (int cyc = 0; cyc < 400 && dones < 2; cyc++) begin
            cmd_valid = (accepts < 2);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                accepts++;
                if (accepts == 2) second_at_done = done;
            end
            if (done) dones++;
            now_m1 = (op_out == 32'h1);
            if (prev_m1 && !now_m1 && first_end < 0) first_end = cyc;
            if (!prev_m1 && now_m1 && first_end >= 0 && second_start < 0) second_start = cyc;
            prev_m1 = now_m1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd2);
        check("b2b_dones", 32'(dones), 32'd2);
        check("b2b_second_accept_on_done", {31'b0, second_at_done}, 32'd1);
        check("b2b_mode0_gap_ge_15", {31'b0, (first_end >= 0 && second_start - first_end >= 15)}, 32'd1);

        // Reset asserted mid-compute.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_data = 18'h10001;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("midrst_pre_enable", {31'b0, ctl_enable}, 32'd1);
        check("midrst_pre_op", op_out, 32'h00010001);
        reset = 1'b0;
        #1;
        check("midrst_enable", {31'b0, ctl_enable}, 32'd0);
        check("midrst_op_out", op_out, 32'd0);
        check("midrst_ready", {30'b0, cmd_ready, wr_ready}, 32'd0);
        check("midrst_flags", {29'b0, busy, done, err}, 32'd0);
        check("midrst_perf", perf_busy | perf_stall, 32'd0);
        exp_busy_tot = 0; exp_stall_tot = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        run_vec(vecs[0], 5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
